// File: rtl/alu_32bit.sv
// Registered single-issue ALU: add, sub, and, or with NZCV flags and one-cycle latency.
// Optional build macro ALU_SATURATE_EN clamps signed-overflowing add/sub results.
module alu_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       c,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             c;
      logic             v;
   } arith_t;

   // Subtraction reuses the adder as a + ~b + 1, so carry is NOT borrow.
   function automatic arith_t add_sub(input logic [WIDTH-1:0] op_a,
                                      input logic [WIDTH-1:0] op_b,
                                      input logic             do_sub);
      arith_t           r;
      logic [WIDTH-1:0] b_eff;
      logic [WIDTH:0]   sum;
      b_eff = do_sub ? ~op_b : op_b;
      sum   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, do_sub};
      r.y   = sum[WIDTH-1:0];
      r.c   = sum[WIDTH];
      r.v   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (r.y[WIDTH-1] != op_a[WIDTH-1]);
      return r;
   endfunction

`ifdef ALU_SATURATE_EN
   // On overflow the true result always has the sign of operand a.
   function automatic logic [WIDTH-1:0] sat_value(input logic neg);
      return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   arith_t           arith_s;
   logic [WIDTH-1:0] res_y_s;
   logic             res_c_s;
   logic             res_v_s;

   logic [WIDTH-1:0] y_r;
   logic             out_valid_r;
   logic             zero_r;
   logic             negative_r;
   logic             carry_r;
   logic             overflow_r;

   // Next-result decode: every opcode handled explicitly.
   always_comb begin
      arith_s = add_sub(a, b, 1'b0);
      res_y_s = {WIDTH{1'b0}};
      res_c_s = 1'b0;
      res_v_s = 1'b0;
      case (c)
         OP_ADD: begin
            arith_s = add_sub(a, b, 1'b0);
            res_y_s = arith_s.y;
            res_c_s = arith_s.c;
            res_v_s = arith_s.v;
         end
         OP_SUB: begin
            arith_s = add_sub(a, b, 1'b1);
            res_y_s = arith_s.y;
            res_c_s = arith_s.c;
            res_v_s = arith_s.v;
         end
         OP_AND: begin
            res_y_s = a & b;
         end
         OP_OR: begin
            res_y_s = a | b;
         end
         default: begin
            res_y_s = {WIDTH{1'b0}};
         end
      endcase
`ifdef ALU_SATURATE_EN
      if (res_v_s) begin
         res_y_s = sat_value(a[WIDTH-1]);
      end else begin
         res_y_s = res_y_s;
      end
`endif
   end

   // Output register: reset wins, accepted ops load, idle cycles hold y and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_r         <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         zero_r      <= 1'b0;
         negative_r  <= 1'b0;
         carry_r     <= 1'b0;
         overflow_r  <= 1'b0;
      end else if (in_valid) begin
         y_r         <= res_y_s;
         out_valid_r <= 1'b1;
         zero_r      <= (res_y_s == {WIDTH{1'b0}});
         negative_r  <= res_y_s[WIDTH-1];
         carry_r     <= res_c_s;
         overflow_r  <= res_v_s;
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   assign y         = y_r;
   assign out_valid = out_valid_r;
   assign zero      = zero_r;
   assign negative  = negative_r;
   assign carry     = carry_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed table, random ops, reset and idle sequences.
module tb_alu_32bit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  c;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] y;
   logic        out_valid;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   alu_32bit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .c(c), .a(a), .b(b),
      .y(y), .out_valid(out_valid), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] y;
      logic        n;
      logic        z;
      logic        cy;
      logic        v;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  c;
      res_t        exp;
   } vec_t;

   res_t queue_q[$];
   res_t held;
   int   n_checks;
   int   n_pass;
   logic exp_valid;

   // Reference model built from wide signed/unsigned arithmetic.
   function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mc);
      res_t        r;
      logic [32:0] s;
      longint      sa;
      r  = '0;
      sa = 0;
      case (mc)
         2'b00: begin
            s    = {1'b0, ma} + {1'b0, mb};
            r.y  = s[31:0];
            r.cy = s[32];
            sa   = longint'($signed(ma)) + longint'($signed(mb));
         end
         2'b01: begin
            r.y  = ma - mb;
            r.cy = (ma >= mb);
            sa   = longint'($signed(ma)) - longint'($signed(mb));
         end
         2'b10: r.y = ma & mb;
         default: r.y = ma | mb;
      endcase
      r.v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
`ifdef ALU_SATURATE_EN
      if (r.v) r.y = (sa > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      r.z = (r.y == 32'h0);
      r.n = r.y[31];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // One clock: drive, push expected on accept, then compare one step after the edge.
   task automatic cycle(input logic r, input logic v, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [1:0] ic, input res_t e);
      res_t got;
      rst = r; in_valid = v; a = ia; b = ib; c = ic;
      if (v && !r) queue_q.push_back(e);
      exp_valid = v && !r;
      @(posedge clk);
      #1;
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (r) begin
         held = '0;
      end else if (exp_valid) begin
         if (queue_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: queue empty, got y=0x%08h expected an entry", y);
         end else begin
            held = queue_q.pop_front();
         end
      end
      got = '{y: y, n: negative, z: zero, cy: carry, v: overflow};
      check("y", got.y, held.y);
      check("nzcv", {28'b0, got.n, got.z, got.cy, got.v}, {28'b0, held.n, held.z, held.cy, held.v});
   endtask

   vec_t tbl[9];
   res_t none;

   initial begin
      n_checks = 0; n_pass = 0; held = '0; none = '0;
      rst = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0; c = 2'b00;

      tbl[0] = '{32'hFFFF_FFFB, 32'h0000_0003, 2'b00, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[1] = '{32'hFFFF_FFFB, 32'h0000_0003, 2'b01, '{32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b0}};
      tbl[2] = '{32'hFFFF_FFFB, 32'h0000_0003, 2'b10, '{32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[3] = '{32'hFFFF_FFFB, 32'h0000_0003, 2'b11, '{32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 1'b0}};
`ifdef ALU_SATURATE_EN
      tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[7] = '{32'h8000_0000, 32'h0000_0001, 2'b01, '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1}};
`else
      tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
      tbl[7] = '{32'h8000_0000, 32'h0000_0001, 2'b01, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}};
`endif
      tbl[5] = '{32'h1234_5678, 32'h1234_5678, 2'b01, '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
      tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
      tbl[8] = '{32'h0000_0000, 32'h0000_0001, 2'b01, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};

      // Reset state
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, none);
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, none);

      // Directed table, back-to-back
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, none);

      // Random back-to-back ops with occasional bubbles
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [1:0]  rc;
         logic        rv;
         ra = $urandom; rb = $urandom; rc = 2'($urandom_range(3, 0));
         if (i % 8 == 3) rb = 32'h8000_0000;
         rv = ($urandom_range(3, 0) != 0);
         cycle(1'b0, rv, ra, rb, rc, model(ra, rb, rc));
      end

      // Reset together with in_valid discards the op, then idle holds zero
      cycle(1'b0, 1'b1, 32'h0000_0009, 32'h0000_0002, 2'b00, model(32'h9, 32'h2, 2'b00));
      cycle(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003, 2'b00, none);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 2'b00, none);

      // Accept 10-4 then idle two cycles: y holds 6
      cycle(1'b0, 1'b1, 32'd10, 32'd4, 2'b01, '{32'h0000_0006, 1'b0, 1'b0, 1'b1, 1'b0});
      cycle(1'b0, 1'b0, 32'd77, 32'd1, 2'b00, none);
      cycle(1'b0, 1'b0, 32'd77, 32'd1, 2'b00, none);

      if (queue_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", queue_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_32bit.md
Name: alu_32bit

Overview:
32-bit registered ALU performing add, subtract, bitwise AND and bitwise OR on two operands, selected by a 2-bit opcode.
- Result and status flags registered: one-cycle latency from accepted inputs to output.
- Sits in the datapath as a single-issue execution unit; upstream presents operands with a valid strobe, downstream samples y/flags when out_valid is high.

Parameters:
- WIDTH, 32, operand/result width in bits; all rules below hold for any WIDTH >= 2, tested at 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/opcode valid this cycle
- c  input  2  opcode: 00 add, 01 sub, 10 and, 11 or
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- y  output  WIDTH  registered result
- out_valid  output  1  y/flags updated from an op accepted last cycle
- zero  output  1  y == 0
- negative  output  1  y[WIDTH-1]
- carry  output  1  add: carry-out; sub: NOT borrow (1 when a >= b unsigned); and/or: 0
- overflow  output  1  signed overflow for add/sub; 0 for and/or

Behaviour:
- Reset: on a rising clk edge with rst=1, y=0, out_valid=0, zero=0, negative=0, carry=0, overflow=0. rst has priority over in_valid.
- Accept: on a rising edge with rst=0 and in_valid=1, compute from a, b, c and register y and all flags. out_valid=1 on the following cycle.
- Idle: with in_valid=0, y and flags hold their last values; out_valid=0 next cycle.
- Latency: exactly 1 cycle, fully pipelined; back-to-back in_valid accepted every cycle, with no stall or ready signal.
- Add: y = (a + b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = (a[msb] == b[msb]) && (y[msb] != a[msb]).
- Sub: computed as a + ~b + 1; y = (a - b) mod 2^WIDTH; carry = carry-out of that sum; overflow = (a[msb] != b[msb]) && (y[msb] != a[msb]).
- And/or: y = a & b / a | b; carry=0, overflow=0.
- zero and negative are always derived from the registered y, including the saturated value when ALU_SATURATE_EN is defined.
- Wrap-around: without saturation, add/sub wrap modulo 2^WIDTH with no exception.
- Reset mid-stream: an op accepted in the same cycle rst=1 is discarded; out_valid stays 0 on the next cycle.
- X-free: all registers reset; no latches; combinational next-state logic is fully case-covered (default to the and/or branch is not allowed; all four codes are decoded explicitly).

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined: on add/sub with signed overflow, y saturates to 0x7FFF_FFFF when the true result is positive, or 0x8000_0000 when it is negative. overflow still reports 1 and carry is unchanged.
- Not defined: y wraps as described above. Flag behaviour is otherwise identical.

Test Plan:
- a=0xFFFF_FFFB, b=0x0000_0003, c=00, in_valid=1 -> next cycle y=0xFFFF_FFFE, out_valid=1, N=1, Z=0, C=0, V=0.
- Same a/b, c=01 -> y=0xFFFF_FFF8, N=1, C=1, V=0. c=10 -> y=0x0000_0003, N=0, C=0. c=11 -> y=0xFFFF_FFFB, N=1. Drive the four opcodes on consecutive cycles and check each result one cycle later.
- a=0x7FFF_FFFF, b=0x0000_0001, c=00 -> y=0x8000_0000, V=1, N=1, C=0. With ALU_SATURATE_EN defined -> y=0x7FFF_FFFF, V=1, N=0.
- a=b=0x1234_5678, c=01 -> y=0, Z=1, C=1, V=0. Also a=0xFFFF_FFFF, b=1, c=00 -> y=0, Z=1, C=1, V=0.
- Assert rst=1 together with in_valid=1 (a=5, b=3, c=00) -> next cycle y=0, all flags 0, out_valid=0. After release, in_valid=0 for 3 cycles -> y holds 0 and out_valid stays 0.
- Accept a=10, b=4, c=01 (y=6), then in_valid=0 for 2 cycles -> y stays 6, out_valid 1 then 0.
